matmul_tile_sequencer: RTL

Sequences a tiled matrix multiply C = A(n×m) · B(m×p) over the shared 3x3-block data memory. For each 3x3 output tile it fetches the A and B tiles, then issues one accumulate strobe per reduction step and writes the finished C tile back. It emits the tile base address, the row-stride (`columns`) for the 3x3 address expander, latch/accumulate strobes for the multiply-accumulate datapath, and the memory write enable. It sits between the top-level start/done handshake and the memory/3x3 addressing path.

---
 rtl/matmul_tile_sequencer_pkg.sv | 31 +++
 rtl/matmul_tile_sequencer_tile_addr_walker.sv | 156 +++++++++++++++
 rtl/matmul_tile_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/matmul_tile_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matmul_tile_sequencer_pkg
// Description : Shared types and helpers for the tiled matrix-multiply
//               sequencer: FSM state encoding, tile edge constant and the
//               last-step test used by the i/j/k loop counters.
// Revision    : 1.0 - initial release
// ============================================================================
package matmul_tile_sequencer_pkg;

  // Edge length of one square block in the shared data memory.
  localparam int unsigned TILE = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_MAC    = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // True when idx is the final tiled step along a dimension of size dim.
  // Evaluated at 32 bits so idx+TILE never wraps for indices near the top
  // of the address range.
  function automatic logic is_last_step(input logic [31:0] idx, input logic [31:0] dim);
    return (idx + TILE) >= dim;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matmul_tile_sequencer_tile_addr_walker.sv
`default_nettype none
// ============================================================================
// Module      : matmul_tile_sequencer_tile_addr_walker
// Description : i/j/k tile counters with running A/B/C element pointers.
//               Every address is built by addition only, wrapping modulo
//               2^ADDR_WIDTH, and last-step flags are exported to the FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_tile_sequencer_tile_addr_walker
  import matmul_tile_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  step_k,
  input  logic                  step_tile,
  input  logic [ADDR_WIDTH-1:0] n,
  input  logic [ADDR_WIDTH-1:0] m,
  input  logic [ADDR_WIDTH-1:0] p,
  input  logic [ADDR_WIDTH-1:0] a_base,
  input  logic [ADDR_WIDTH-1:0] b_base,
  input  logic [ADDR_WIDTH-1:0] c_base,
  output logic [ADDR_WIDTH-1:0] a_ptr,
  output logic [ADDR_WIDTH-1:0] b_ptr,
  output logic [ADDR_WIDTH-1:0] c_ptr,
  output logic [ADDR_WIDTH-1:0] m_dim,
  output logic [ADDR_WIDTH-1:0] p_dim,
  output logic                  k_first,
  output logic                  k_last,
  output logic                  j_last,
  output logic                  i_last
);

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(TILE);

  // Three rows of a matrix with row length d, without a multiplier.
  function automatic logic [ADDR_WIDTH-1:0] span3(input logic [ADDR_WIDTH-1:0] d);
    return (d << 1) + d;
  endfunction

  logic [ADDR_WIDTH-1:0] n_q, n_d, m_q, m_d, p_q, p_d;
  logic [ADDR_WIDTH-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ADDR_WIDTH-1:0] a_row_q, a_row_d, a_ptr_q, a_ptr_d;
  logic [ADDR_WIDTH-1:0] b_base_q, b_base_d, b_col_q, b_col_d, b_ptr_q, b_ptr_d;
  logic [ADDR_WIDTH-1:0] c_row_q, c_row_d, c_ptr_q, c_ptr_d;
  logic [ADDR_WIDTH-1:0] m3, p3;

  assign m3 = span3(m_q);
  assign p3 = span3(p_q);

  assign k_first = (k_q == '0);
  assign k_last  = is_last_step(32'(k_q), 32'(m_q));
  assign j_last  = is_last_step(32'(j_q), 32'(p_q));
  assign i_last  = is_last_step(32'(i_q), 32'(n_q));

  assign a_ptr = a_ptr_q;
  assign b_ptr = b_ptr_q;
  assign c_ptr = c_ptr_q;
  assign m_dim = m_q;
  assign p_dim = p_q;

  // Loop advance: k innermost, then j, then i; pointers follow their indices.
  always_comb begin
    n_d      = n_q;
    m_d      = m_q;
    p_d      = p_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    a_row_d  = a_row_q;
    a_ptr_d  = a_ptr_q;
    b_base_d = b_base_q;
    b_col_d  = b_col_q;
    b_ptr_d  = b_ptr_q;
    c_row_d  = c_row_q;
    c_ptr_d  = c_ptr_q;
    if (init) begin
      n_d      = n;
      m_d      = m;
      p_d      = p;
      i_d      = '0;
      j_d      = '0;
      k_d      = '0;
      a_row_d  = a_base;
      a_ptr_d  = a_base;
      b_base_d = b_base;
      b_col_d  = b_base;
      b_ptr_d  = b_base;
      c_row_d  = c_base;
      c_ptr_d  = c_base;
    end else if (step_k) begin
      k_d     = k_q + STEP;
      a_ptr_d = a_ptr_q + STEP;
      b_ptr_d = b_ptr_q + p3;
    end else if (step_tile) begin
      k_d = '0;
      if (!j_last) begin
        // Next column tile on the same row band: A restarts at the row,
        // B restarts at the top of the next column band.
        j_d     = j_q + STEP;
        a_ptr_d = a_row_q;
        b_col_d = b_col_q + STEP;
        b_ptr_d = b_col_q + STEP;
        c_ptr_d = c_ptr_q + STEP;
      end else begin
        j_d     = '0;
        b_col_d = b_base_q;
        b_ptr_d = b_base_q;
        if (!i_last) begin
          i_d     = i_q + STEP;
          a_row_d = a_row_q + m3;
          a_ptr_d = a_row_q + m3;
          c_row_d = c_row_q + p3;
          c_ptr_d = c_row_q + p3;
        end
      end
    end
  end

  // Counter and pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q      <= '0;
      m_q      <= '0;
      p_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      a_row_q  <= '0;
      a_ptr_q  <= '0;
      b_base_q <= '0;
      b_col_q  <= '0;
      b_ptr_q  <= '0;
      c_row_q  <= '0;
      c_ptr_q  <= '0;
    end else begin
      n_q      <= n_d;
      m_q      <= m_d;
      p_q      <= p_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      a_row_q  <= a_row_d;
      a_ptr_q  <= a_ptr_d;
      b_base_q <= b_base_d;
      b_col_q  <= b_col_d;
      b_ptr_q  <= b_ptr_d;
      c_row_q  <= c_row_d;
      c_ptr_q  <= c_ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/matmul_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : matmul_tile_sequencer
// Description : Sequences a tiled C = A*B over 3x3 memory blocks. For each
//               output tile it fetches A and B tiles per reduction step,
//               strobes the accumulator, then writes the C tile back.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_tile_sequencer
  import matmul_tile_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] n,
  input  logic [ADDR_WIDTH-1:0] m,
  input  logic [ADDR_WIDTH-1:0] p,
  input  logic [ADDR_WIDTH-1:0] a_base,
  input  logic [ADDR_WIDTH-1:0] b_base,
  input  logic [ADDR_WIDTH-1:0] c_base,
  output logic [ADDR_WIDTH-1:0] tile_addr,
  output logic [ADDR_WIDTH-1:0] columns,
  output logic                  a_latch,
  output logic                  b_latch,
  output logic                  acc_clr,
  output logic                  acc_en,
  output logic                  dm_we,
  output logic                  busy,
  output logic                  done
);

  state_t state_q, state_d;

  logic                  walk_init, walk_step_k, walk_step_tile;
  logic [ADDR_WIDTH-1:0] a_ptr, b_ptr, c_ptr, m_dim, p_dim;
  logic                  k_first, k_last, j_last, i_last;

  matmul_tile_sequencer_tile_addr_walker #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_walker (
    .clk       (clk),
    .reset     (reset),
    .init      (walk_init),
    .step_k    (walk_step_k),
    .step_tile (walk_step_tile),
    .n         (n),
    .m         (m),
    .p         (p),
    .a_base    (a_base),
    .b_base    (b_base),
    .c_base    (c_base),
    .a_ptr     (a_ptr),
    .b_ptr     (b_ptr),
    .c_ptr     (c_ptr),
    .m_dim     (m_dim),
    .p_dim     (p_dim),
    .k_first   (k_first),
    .k_last    (k_last),
    .j_last    (j_last),
    .i_last    (i_last)
  );

  assign busy = (state_q != ST_IDLE);

  // Next state plus state-decoded outputs; every output is low in IDLE.
  always_comb begin
    state_d        = state_q;
    walk_init      = 1'b0;
    walk_step_k    = 1'b0;
    walk_step_tile = 1'b0;
    tile_addr      = '0;
    columns        = '0;
    a_latch        = 1'b0;
    b_latch        = 1'b0;
    acc_clr        = 1'b0;
    acc_en         = 1'b0;
    dm_we          = 1'b0;
    done           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          walk_init = 1'b1;
          if ((n == '0) || (m == '0) || (p == '0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD_A;
          end
        end
      end
      ST_LOAD_A: begin
        tile_addr = a_ptr;
        columns   = m_dim;
        a_latch   = 1'b1;
        acc_clr   = k_first;
        state_d   = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        tile_addr = b_ptr;
        columns   = p_dim;
        b_latch   = 1'b1;
        state_d   = ST_MAC;
      end
      ST_MAC: begin
        acc_en = 1'b1;
        if (!k_last) begin
          walk_step_k = 1'b1;
          state_d     = ST_LOAD_A;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        tile_addr      = c_ptr;
        columns        = p_dim;
        dm_we          = 1'b1;
        walk_step_tile = 1'b1;
        if (j_last && i_last) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_LOAD_A;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any job in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
`default_nettype wire
